wb_rr_arbiter: RTL

Parametrised N-master to 1-slave Wishbone arbiter for the user project area: it shares one Wishbone slave (system RAM) among any number of masters (CPU path, DMA read/write engines, future accelerators). It generalises the fixed two-master CPU/DMA SDRAM arbiter in three ways: configurable master count, a selectable fixed-priority or round-robin policy, and a stall watchdog that returns a bus error instead of hanging the bus. It sits between the address decoder outputs and the `system_ram` Wishbone slave port.

---
 rtl/wb_rr_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: shares one Wishbone slave among NUM_MASTERS masters with fixed or round-robin
// arbitration, locked ownership for block cycles, and a stall watchdog that answers a hung slave with err.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int RR_MODE     = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [DW-1:0]               m_dat_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  input  logic [DW-1:0]               s_dat_i,
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        busy_o
);
  localparam int SW = DW / 8;
  localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, ERR} state_t;
  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          idx_q, idx_d, rr_ptr_q, rr_ptr_d, win;
  logic [15:0]            stall_cnt_q, stall_cnt_d;
  logic                   in_grant, g_cyc, stall, timeout;
  int                     gi;

  // First requester at or after base, wrapping at NUM_MASTERS.
  function automatic logic [IW-1:0] pick(input logic [NUM_MASTERS-1:0] req, input int base);
    logic [IW-1:0] w;
    int j;
    w = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      j = base + k;
      if (j >= NUM_MASTERS) j -= NUM_MASTERS;
      if (req[j]) w = IW'(j);
    end
    return w;
  endfunction

  assign win      = pick(m_cyc_i, RR_MODE != 0 ? int'(rr_ptr_q) : 0);
  assign gi       = int'(idx_q);
  assign in_grant = state_q == GRANT;
  assign g_cyc    = m_cyc_i[gi];
  assign s_cyc_o  = in_grant && g_cyc;
  assign s_stb_o  = in_grant && m_stb_i[gi];
  assign s_we_o   = in_grant && m_we_i[gi];
  assign s_sel_o  = m_sel_i[gi*SW +: SW];
  assign s_adr_o  = m_adr_i[gi*AW +: AW];
  assign s_dat_o  = m_dat_i[gi*DW +: DW];
  assign m_dat_o  = s_dat_i;
  assign m_ack_o  = (in_grant && s_ack_i) ? grant_q : '0;
  assign m_err_o  = (state_q == ERR || (in_grant && s_err_i)) ? grant_q : '0;
  assign grant_o  = grant_q;
  assign busy_o   = state_q != IDLE;
  assign stall    = s_stb_o && !s_ack_i && !s_err_i;
  assign timeout  = TIMEOUT != 0 && stall && stall_cnt_q == 16'(TIMEOUT - 1);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    stall_cnt_d = stall ? (stall_cnt_q == '1 ? stall_cnt_q : stall_cnt_q + 16'd1) : '0;
    if (state_q == IDLE && |m_cyc_i) begin
      state_d  = GRANT;
      grant_d  = NUM_MASTERS'(1) << win;
      idx_d    = win;
      rr_ptr_d = win == IW'(NUM_MASTERS - 1) ? '0 : win + 1'b1;
    end else if (in_grant && !g_cyc) begin
      state_d = IDLE;
      grant_d = '0;
    end else if (in_grant && timeout) begin
      state_d = ERR;
    end else if (state_q == ERR) begin
      state_d = IDLE;
      grant_d = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      idx_q       <= '0;
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      idx_q       <= idx_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule
